// File: rtl/change_dispenser_ctrl.sv
// Change dispenser controller: pays out 10/5/1-unit coins greedily,
// one hopper request at a time, with an ack timeout abort.
module change_dispenser_ctrl #(
    parameter logic [7:0]  INIT10  = 8'd20,
    parameter logic [7:0]  INIT5   = 8'd20,
    parameter logic [7:0]  INIT1   = 8'd20,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] change_amt_i,
    input  logic       refill_i,
    input  logic       hop_ack_i,
    output logic       hop_req_o,
    output logic [1:0] hop_sel_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       short_o,
    output logic       fault_o,
    output logic [7:0] remain_o,
    output logic [7:0] stock10_o,
    output logic [7:0] stock5_o,
    output logic [7:0] stock1_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_ONE  = 2'b01;
    localparam logic [1:0] SEL_FIVE = 2'b10;
    localparam logic [1:0] SEL_TEN  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        REQ,
        DONE
    } state_t;

    state_t        state_q;
    logic          accepted_q;
    logic [7:0]    remain_q;
    logic [7:0]    stock10_q;
    logic [7:0]    stock5_q;
    logic [7:0]    stock1_q;
    logic          hop_req_q;
    logic [1:0]    hop_sel_q;
    logic          busy_q;
    logic          done_q;
    logic          short_q;
    logic          fault_q;
    logic [TW-1:0] tmr_q;

    logic [1:0]    sel_d;
    logic [7:0]    coin_val;

    // Greedy choice from what is still owed and what is in stock.
    always_comb begin
        sel_d = SEL_NONE;
        if (remain_q >= 8'd10 && stock10_q != 8'd0) begin
            sel_d = SEL_TEN;
        end else if (remain_q >= 8'd5 && stock5_q != 8'd0) begin
            sel_d = SEL_FIVE;
        end else if (remain_q != 8'd0 && stock1_q != 8'd0) begin
            sel_d = SEL_ONE;
        end
    end

    always_comb begin
        coin_val = 8'd0;
        case (hop_sel_q)
            SEL_TEN:  coin_val = 8'd10;
            SEL_FIVE: coin_val = 8'd5;
            SEL_ONE:  coin_val = 8'd1;
            default:  coin_val = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            accepted_q <= 1'b0;
            remain_q   <= 8'd0;
            stock10_q  <= INIT10;
            stock5_q   <= INIT5;
            stock1_q   <= INIT1;
            hop_req_q  <= 1'b0;
            hop_sel_q  <= SEL_NONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            short_q    <= 1'b0;
            fault_q    <= 1'b0;
            tmr_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // Accepted request spends one cycle here before SELECT.
                    if (accepted_q) begin
                        accepted_q <= 1'b0;
                        state_q    <= SELECT;
                    end else if (start_i) begin
                        accepted_q <= 1'b1;
                        busy_q     <= 1'b1;
                        remain_q   <= change_amt_i;
                        short_q    <= 1'b0;
                        fault_q    <= 1'b0;
                    end else if (refill_i) begin
                        stock10_q <= INIT10;
                        stock5_q  <= INIT5;
                        stock1_q  <= INIT1;
                    end
                end
                SELECT: begin
                    if (sel_d != SEL_NONE) begin
                        hop_req_q <= 1'b1;
                        hop_sel_q <= sel_d;
                        tmr_q     <= '0;
                        state_q   <= REQ;
                    end else begin
                        done_q  <= 1'b1;
                        short_q <= (remain_q != 8'd0);
                        state_q <= DONE;
                    end
                end
                REQ: begin
                    if (hop_ack_i) begin
                        remain_q  <= remain_q - coin_val;
                        case (hop_sel_q)
                            SEL_TEN:  stock10_q <= stock10_q - 8'd1;
                            SEL_FIVE: stock5_q  <= stock5_q - 8'd1;
                            SEL_ONE:  stock1_q  <= stock1_q - 8'd1;
                            default:  ;
                        endcase
                        hop_req_q <= 1'b0;
                        hop_sel_q <= SEL_NONE;
                        state_q   <= SELECT;
                    end else if (tmr_q == TMR_LAST) begin
                        hop_req_q <= 1'b0;
                        hop_sel_q <= SEL_NONE;
                        fault_q   <= 1'b1;
                        short_q   <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hop_req_o = hop_req_q;
    assign hop_sel_o = hop_sel_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign short_o   = short_q;
    assign fault_o   = fault_q;
    assign remain_o  = remain_q;
    assign stock10_o = stock10_q;
    assign stock5_o  = stock5_q;
    assign stock1_o  = stock1_q;

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Bench for change_dispenser_ctrl: two instances (default and sparse
// stock), transaction model of greedy payout plus cycle timing checks.
module tb_change_dispenser_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start [2];
    logic       refill[2];
    logic       ack   [2];
    logic [7:0] amt   [2];
    logic       req   [2];
    logic [1:0] sel   [2];
    logic       busy  [2];
    logic       done  [2];
    logic       shrt  [2];
    logic       flt   [2];
    logic [7:0] rem   [2];
    logic [7:0] s10   [2];
    logic [7:0] s5    [2];
    logic [7:0] s1    [2];

    int init10[2] = '{20, 1};
    int init5 [2] = '{20, 20};
    int init1 [2] = '{20, 0};
    int tmo   [2] = '{16, 4};

    int m10[2];
    int m5 [2];
    int m1 [2];

    int n_chk  = 0;
    int n_fail = 0;

    change_dispenser_ctrl u_dut0 (
        .clk(clk), .rst(rst),
        .start_i(start[0]), .change_amt_i(amt[0]),
        .refill_i(refill[0]), .hop_ack_i(ack[0]),
        .hop_req_o(req[0]), .hop_sel_o(sel[0]),
        .busy_o(busy[0]), .done_o(done[0]),
        .short_o(shrt[0]), .fault_o(flt[0]),
        .remain_o(rem[0]), .stock10_o(s10[0]),
        .stock5_o(s5[0]), .stock1_o(s1[0])
    );

    change_dispenser_ctrl #(
        .INIT10(8'd1), .INIT5(8'd20), .INIT1(8'd0), .TIMEOUT(4)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .start_i(start[1]), .change_amt_i(amt[1]),
        .refill_i(refill[1]), .hop_ack_i(ack[1]),
        .hop_req_o(req[1]), .hop_sel_o(sel[1]),
        .busy_o(busy[1]), .done_o(done[1]),
        .short_o(shrt[1]), .fault_o(flt[1]),
        .remain_o(rem[1]), .stock10_o(s10[1]),
        .stock5_o(s5[1]), .stock1_o(s1[1])
    );

    task automatic chk(int i, string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL inst%0d %s: got %0d expected %0d (t=%0t)",
                     i, nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            if (!req[i]) chk(i, "sel_when_no_req", sel[i], 0);
    endtask

    function automatic int code_of(int c);
        if (c == 10) return 3;
        if (c == 5) return 2;
        return 1;
    endfunction

    task automatic chk_stocks(int i);
        chk(i, "stock10", s10[i], m10[i]);
        chk(i, "stock5", s5[i], m5[i]);
        chk(i, "stock1", s1[i], m1[i]);
    endtask

    task automatic model_init();
        for (int i = 0; i < 2; i++) begin
            m10[i] = init10[i];
            m5[i]  = init5[i];
            m1[i]  = init1[i];
        end
    endtask

    task automatic chk_reset_state();
        for (int i = 0; i < 2; i++) begin
            chk(i, "rst_req", req[i], 0);
            chk(i, "rst_sel", sel[i], 0);
            chk(i, "rst_busy", busy[i], 0);
            chk(i, "rst_done", done[i], 0);
            chk(i, "rst_short", shrt[i], 0);
            chk(i, "rst_fault", flt[i], 0);
            chk(i, "rst_remain", rem[i], 0);
            chk_stocks(i);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_init();
        chk_reset_state();
    endtask

    task automatic do_refill(int i);
        refill[i] = 1'b1;
        tick();
        refill[i] = 1'b0;
        m10[i] = init10[i];
        m5[i]  = init5[i];
        m1[i]  = init1[i];
        chk_stocks(i);
        chk(i, "refill_busy", busy[i], 0);
    endtask

    // One full transaction: start, hopper acks (or silence), completion.
    task automatic dispense(int i, int a, bit hold, bit with_refill);
        int r;
        int t10, t5, t1;
        int coins[$];
        int k;
        int c;
        r = a; t10 = m10[i]; t5 = m5[i]; t1 = m1[i];
        while (r > 0) begin
            if (r >= 10 && t10 > 0) begin
                coins.push_back(10); r -= 10; t10--;
            end else if (r >= 5 && t5 > 0) begin
                coins.push_back(5); r -= 5; t5--;
            end else if (r >= 1 && t1 > 0) begin
                coins.push_back(1); r -= 1; t1--;
            end else break;
        end
        if (coins.size() == 0) hold = 1'b0;

        start[i]  = 1'b1;
        amt[i]    = 8'(a);
        refill[i] = with_refill;
        tick();
        start[i]  = 1'b0;
        refill[i] = 1'b0;
        amt[i]    = 8'($urandom);
        chk(i, "latch_remain", rem[i], a);
        chk(i, "short_cleared", shrt[i], 0);
        chk(i, "fault_cleared", flt[i], 0);
        chk(i, "req_n", req[i], 0);
        ack[i] = 1'($urandom);
        tick();
        chk(i, "req_n1", req[i], 0);
        chk(i, "done_n1", done[i], 0);
        ack[i] = 1'($urandom);
        tick();
        ack[i] = 1'b0;
        r = a;

        if (hold) begin
            chk(i, "req_up_first", req[i], 1);
            chk(i, "sel_first", sel[i], code_of(coins[0]));
            k = 0;
            while (req[i] && k < tmo[i] + 4) begin
                tick();
                k++;
            end
            chk(i, "timeout_cycles", k, tmo[i]);
            chk(i, "to_done", done[i], 1);
            chk(i, "to_fault", flt[i], 1);
            chk(i, "to_short", shrt[i], 1);
            chk(i, "to_remain", rem[i], a);
            chk_stocks(i);
        end else begin
            foreach (coins[j]) begin
                c = coins[j];
                chk(i, "req_up", req[i], 1);
                chk(i, "sel", sel[i], code_of(c));
                chk(i, "busy_req", busy[i], 1);
                repeat ($urandom_range(0, 3)) begin
                    start[i]  = 1'($urandom);
                    refill[i] = 1'($urandom);
                    amt[i]    = 8'($urandom);
                    tick();
                    chk(i, "req_hold", req[i], 1);
                    chk(i, "sel_hold", sel[i], code_of(c));
                end
                start[i]  = 1'b0;
                refill[i] = 1'b0;
                ack[i]    = 1'b1;
                tick();
                ack[i] = 1'b0;
                r -= c;
                if (c == 10) m10[i]--;
                else if (c == 5) m5[i]--;
                else m1[i]--;
                chk(i, "req_drop", req[i], 0);
                chk(i, "remain_step", rem[i], r);
                chk_stocks(i);
                ack[i] = 1'($urandom);
                tick();
                ack[i] = 1'b0;
            end
            chk(i, "done", done[i], 1);
            chk(i, "done_req", req[i], 0);
            chk(i, "done_short", shrt[i], (r > 0) ? 1 : 0);
            chk(i, "done_remain", rem[i], r);
            chk(i, "done_fault", flt[i], 0);
            chk_stocks(i);
        end
        chk(i, "busy_done", busy[i], 1);
        tick();
        chk(i, "done_pulse_end", done[i], 0);
        chk(i, "idle_busy", busy[i], 0);
        chk(i, "short_held", shrt[i], (hold || r > 0) ? 1 : 0);
        chk(i, "fault_held", flt[i], hold ? 1 : 0);
    endtask

    task automatic reset_mid(int i, int a);
        start[i] = 1'b1;
        amt[i]   = 8'(a);
        tick();
        start[i] = 1'b0;
        tick();
        tick();
        chk(i, "mid_req_up", req[i], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_init();
        chk_reset_state();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; refill[i] = 1'b0;
            ack[i] = 1'b0; amt[i] = 8'd0;
        end
        repeat (2) @(posedge clk);
        do_reset();

        dispense(0, 26, 1'b0, 1'b0);
        chk(0, "lit26_s10", s10[0], 18);
        chk(0, "lit26_s5", s5[0], 19);
        chk(0, "lit26_s1", s1[0], 19);
        chk(0, "lit26_remain", rem[0], 0);
        chk(0, "lit26_short", shrt[0], 0);

        dispense(0, 0, 1'b0, 1'b0);
        chk(0, "lit0_short", shrt[0], 0);

        dispense(1, 25, 1'b0, 1'b0);
        chk(1, "lit25_s10", s10[1], 0);
        chk(1, "lit25_s5", s5[1], 17);
        chk(1, "lit25_short", shrt[1], 0);

        dispense(1, 3, 1'b0, 1'b0);
        chk(1, "lit3_short", shrt[1], 1);
        chk(1, "lit3_remain", rem[1], 3);

        do_reset();
        dispense(0, 10, 1'b1, 1'b0);
        chk(0, "litto_fault", flt[0], 1);
        chk(0, "litto_remain", rem[0], 10);
        chk(0, "litto_s10", s10[0], 20);
        dispense(0, 5, 1'b0, 1'b0);
        chk(0, "litto_cleared", flt[0], 0);

        dispense(1, 7, 1'b1, 1'b0);

        reset_mid(0, 10);
        chk(0, "litmid_s10", s10[0], 20);

        dispense(0, 200, 1'b0, 1'b0);
        chk(0, "litdep_s10", s10[0], 0);
        dispense(0, 0, 1'b0, 1'b1);
        chk(0, "lit_start_wins", s10[0], 0);
        do_refill(0);
        chk(0, "lit_refill_s10", s10[0], 20);

        for (int n = 0; n < 60; n++) begin
            int i;
            i = int'($urandom_range(0, 1));
            case ($urandom_range(0, 15))
                0:       do_refill(i);
                1:       if (m10[i] + m5[i] + m1[i] > 0)
                             reset_mid(i, 60);
                2, 3:    dispense(i, int'($urandom_range(1, 80)), 1'b1, 1'b0);
                4:       dispense(i, int'($urandom_range(0, 255)), 1'b0, 1'b1);
                default: dispense(i, int'($urandom_range(0, 80)), 1'b0, 1'b0);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
